// File: rtl/my_cache_dm_pkg.sv
// ============================================================================
// my_cache_dm_pkg : shared types and constants for the direct-mapped cache
// Revision 1.0
// ============================================================================
`default_nettype none

package my_cache_dm_pkg;

  localparam int CACHE_DATA_W   = 32;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_TAG_W      = CACHE_DATA_W - DEF_INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MISS = 3'd1,
    WR_THRU = 3'd2,
    ATOMIC  = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic int tag_width(input int index_bits);
    return CACHE_DATA_W - index_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_cache_dm_tag_store.sv
// ============================================================================
// cache_tag_store : valid/tag/data arrays with hit compare, fill and invalidate
// Revision 1.0
// ============================================================================
`default_nettype none

module cache_tag_store
  import my_cache_dm_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int DATA_W     = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr,
  output logic              hit,
  output logic              tag_match,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = DATA_W - INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags  [LINES];
  logic [DATA_W-1:0]     data  [LINES];
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;

  assign idx       = addr[INDEX_BITS-1:0];
  assign tag       = addr[DATA_W-1:INDEX_BITS];
  assign tag_match = (tags[idx] == tag);
  assign hit       = valid[idx] & tag_match;
  assign rd_data   = data[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[idx] <= 1'b1;
    end else if (inv_en && tag_match) begin
      valid[idx] <= 1'b0;
    end
  end

  // Tag and data need no reset: a line is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[idx] <= tag;
      data[idx] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/my_cache_dm.sv
// ============================================================================
// my_cache_dm : direct-mapped write-through write-allocate cache, one word/line
// Revision 1.0
// ============================================================================
`default_nettype none

module my_cache_dm
  import my_cache_dm_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int DATA_W     = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cpu_data_w,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_atomic,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_data_r,
  input  logic              ram_wait,
  input  logic [DATA_W-1:0] ram_data_r,
  output logic [DATA_W-1:0] ram_data_w,
  output logic [DATA_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_atomic
);

  state_t            state;
  logic              hit;
  logic              tag_match;
  logic [DATA_W-1:0] line_data;
  logic              any_req;
  logic              op_rd;
  logic              rd_hit;
  logic              same_req;
  logic              ram_done;
  logic              fill_en;
  logic              inv_en;
  logic [DATA_W-1:0] fill_data;
  logic [DATA_W-1:0] done_data;
  logic              wait_c;

  logic [DATA_W-1:0] req_addr;
  logic              req_wr;
  logic              req_atomic;
  logic [DATA_W-1:0] data_hold;
  logic [DATA_W-1:0] atomic_data;
  logic              done_atomic_rd;

  cache_tag_store #(
    .INDEX_BITS (INDEX_BITS),
    .DATA_W     (DATA_W)
  ) u_tag_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (cpu_addr),
    .hit       (hit),
    .tag_match (tag_match),
    .rd_data   (line_data),
    .wr_en     (fill_en),
    .wr_data   (fill_data),
    .inv_en    (inv_en)
  );

  // A write wins over a simultaneous read.
  assign any_req   = cpu_read | cpu_write;
  assign op_rd     = cpu_read & ~cpu_write;
  assign rd_hit    = op_rd & ~cpu_atomic & hit;
  assign same_req  = any_req && (cpu_addr == req_addr) &&
                     (cpu_write == req_wr) && (cpu_atomic == req_atomic);
  assign ram_done  = ((state == RD_MISS) || (state == WR_THRU) || (state == ATOMIC)) && !ram_wait;
  assign fill_en   = ram_done && (state != ATOMIC);
  assign inv_en    = ram_done && (state == ATOMIC);
  assign fill_data = (state == WR_THRU) ? cpu_data_w : ram_data_r;
  assign done_data = done_atomic_rd ? atomic_data : line_data;

  // In DONE a different request is not yet served, so it must still stall.
  always_comb begin
    wait_c = 1'b0;
    case (state)
      IDLE:    wait_c = any_req & ~rd_hit;
      DONE:    wait_c = any_req & ~same_req;
      default: wait_c = 1'b1;
    endcase
  end

  assign cpu_wait = rst_n & wait_c;

  always_comb begin
    cpu_data_r = data_hold;
    if (state == IDLE && rd_hit) begin
      cpu_data_r = line_data;
    end else if (state == DONE) begin
      cpu_data_r = done_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ram_read       <= 1'b0;
      ram_write      <= 1'b0;
      ram_atomic     <= 1'b0;
      ram_addr       <= '0;
      ram_data_w     <= '0;
      req_addr       <= '0;
      req_wr         <= 1'b0;
      req_atomic     <= 1'b0;
      data_hold      <= '0;
      atomic_data    <= '0;
      done_atomic_rd <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_hit) begin
            data_hold <= line_data;
          end else if (any_req) begin
            req_addr   <= cpu_addr;
            req_wr     <= cpu_write;
            req_atomic <= cpu_atomic;
            ram_addr   <= cpu_addr;
            ram_data_w <= cpu_data_w;
            if (cpu_atomic) begin
              state      <= ATOMIC;
              ram_atomic <= 1'b1;
              ram_read   <= op_rd;
              ram_write  <= cpu_write;
            end else if (cpu_write) begin
              state     <= WR_THRU;
              ram_write <= 1'b1;
            end else begin
              state    <= RD_MISS;
              ram_read <= 1'b1;
            end
          end
        end
        RD_MISS, WR_THRU, ATOMIC: begin
          if (!ram_wait) begin
            ram_read       <= 1'b0;
            ram_write      <= 1'b0;
            ram_atomic     <= 1'b0;
            done_atomic_rd <= (state == ATOMIC) && !req_wr;
            if (state == ATOMIC) begin
              atomic_data <= ram_data_r;
            end
            // A filled read line hits on the next IDLE cycle.
            state <= (state == RD_MISS) ? IDLE : DONE;
          end
        end
        DONE: begin
          data_hold <= done_data;
          if (!same_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_my_cache_dm.sv
// ============================================================================
// tb_my_cache_dm : directed + randomized bench against a line-array cache model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_my_cache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_data_w = '0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic        cpu_atomic = 1'b0;
  logic        cpu_wait;
  logic [31:0] cpu_data_r;
  logic        ram_wait = 1'b1;
  logic [31:0] ram_data_r = '0;
  logic [31:0] ram_data_w;
  logic [31:0] ram_addr;
  logic        ram_read;
  logic        ram_write;
  logic        ram_atomic;

  my_cache_dm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_data_w (cpu_data_w),
    .cpu_addr   (cpu_addr),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_atomic (cpu_atomic),
    .cpu_wait   (cpu_wait),
    .cpu_data_r (cpu_data_r),
    .ram_wait   (ram_wait),
    .ram_data_r (ram_data_r),
    .ram_data_w (ram_data_w),
    .ram_addr   (ram_addr),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .ram_atomic (ram_atomic)
  );

  always #5 clk = ~clk;

  // Reference cache: 16 lines of {valid, tag, data}
  bit          m_valid [16];
  logic [27:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] last_data = '0;

  // Per-cycle expectations consumed by the compare process
  bit          exp_en = 0;
  bit          exp_wait, exp_rr, exp_rw, exp_ra, exp_ca, exp_cdw;
  logic [31:0] exp_addr, exp_dw, exp_data;
  bit          pin_hit_en = 0, pin_hit_exp, pin_hit_act;
  bit          pin_d_en = 0;
  logic [31:0] pin_d;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      chk("cpu_wait",   {31'b0, cpu_wait},   {31'b0, exp_wait});
      chk("ram_read",   {31'b0, ram_read},   {31'b0, exp_rr});
      chk("ram_write",  {31'b0, ram_write},  {31'b0, exp_rw});
      chk("ram_atomic", {31'b0, ram_atomic}, {31'b0, exp_ra});
      chk("cpu_data_r", cpu_data_r, exp_data);
      if (exp_ca)     chk("ram_addr", ram_addr, exp_addr);
      if (exp_cdw)    chk("ram_data_w", ram_data_w, exp_dw);
      if (pin_d_en)   chk("pinned_data", cpu_data_r, pin_d);
      if (pin_hit_en) chk("model_hit", {31'b0, pin_hit_act}, {31'b0, pin_hit_exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit w, input bit rr, input bit rw, input bit ra,
                         input bit ca, input logic [31:0] a,
                         input bit cdw, input logic [31:0] dw,
                         input bit nd, input logic [31:0] d);
    exp_wait = w;  exp_rr = rr;  exp_rw = rw;  exp_ra = ra;
    exp_ca = ca;   exp_addr = a; exp_cdw = cdw; exp_dw = dw;
    if (nd) last_data = d;
    exp_data = last_data;
  endtask

  // kind: 0 read, 1 write, 2 atomic read, 3 atomic write; nwait<0 means random
  task automatic xact(input int kind, input logic [31:0] a, input logic [31:0] d,
                      input int nwait, input bit use_fixed, input logic [31:0] fixed,
                      input int hold_extra, input int pin_hit,
                      input bit pd_en, input logic [31:0] pd);
    logic [3:0]  idx;
    logic [27:0] tg;
    logic [31:0] rd, dd;
    bit          hit, is_wr, at, w;
    int          n;
    idx   = a[3:0];
    tg    = a[31:4];
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    is_wr = (kind == 1) || (kind == 3);
    at    = (kind >= 2);
    rd    = '0;
    cpu_addr   = a;
    cpu_data_w = d;
    cpu_atomic = at;
    cpu_write  = is_wr;
    cpu_read   = !is_wr || ($urandom_range(0, 3) == 0);
    pin_hit_en  = (pin_hit >= 0);
    pin_hit_exp = (pin_hit == 1);
    pin_hit_act = hit;
    if (kind == 0 && hit) begin
      pin_d_en = pd_en; pin_d = pd;
      set_exp(0, 0, 0, 0, 0, '0, 0, '0, 1, m_data[idx]);
      step();
      pin_hit_en = 0; pin_d_en = 0;
    end else begin
      set_exp(1, 0, 0, 0, 0, '0, 0, '0, 0, '0);
      step();
      pin_hit_en = 0;
      n = 0;
      do begin
        if (nwait >= 0) w = (n < nwait);
        else            w = (n < 4) && ($urandom_range(0, 2) != 0);
        ram_wait   = w;
        rd         = use_fixed ? fixed : $urandom;
        ram_data_r = rd;
        set_exp(1, !is_wr, is_wr, at, 1, a, is_wr, d, 0, '0);
        step();
        n++;
      end while (w);
      if (at) begin
        if (m_tag[idx] == tg) m_valid[idx] = 0;
      end else begin
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
        m_data[idx]  = is_wr ? d : rd;
      end
      ram_wait = $urandom_range(0, 1);
      pin_d_en = pd_en; pin_d = pd;
      if (kind == 0) begin
        set_exp(0, 0, 0, 0, 0, '0, 0, '0, 1, m_data[idx]);
        step();
      end else begin
        dd = (kind == 2) ? rd : m_data[idx];
        for (int i = 0; i <= hold_extra; i++) begin
          set_exp(0, 0, 0, 0, 0, '0, 0, '0, 1, dd);
          step();
          pin_d_en = 0;
        end
      end
      pin_d_en = 0;
    end
    cpu_read = 0; cpu_write = 0; cpu_atomic = 0;
    set_exp(0, 0, 0, 0, 0, '0, 0, '0, 0, '0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    #1;
    exp_en = 1;
    set_exp(0, 0, 0, 0, 1, '0, 1, '0, 1, '0);
    step();
    step();
    rst_n = 1;

    xact(1, 32'd39, 32'd1115, 2, 0, '0, 1, 0, 1, 32'd1115);
    xact(0, 32'd39, '0, -1, 0, '0, 0, 1, 1, 32'd1115);
    xact(0, 32'd40, '0, 0, 1, 32'd0, 0, 0, 1, 32'd0);
    xact(0, 32'd40, '0, -1, 0, '0, 0, 1, 1, 32'd0);
    xact(0, 32'd70, '0, 2, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF);
    xact(0, 32'd6,  '0, -1, 0, '0, 0, 0, 0, '0);
    xact(0, 32'd70, '0, -1, 0, '0, 0, 0, 0, '0);
    xact(0, 32'd6,  '0, -1, 0, '0, 0, 0, 0, '0);
    xact(3, 32'd39, 32'd5, -1, 0, '0, 0, 1, 0, '0);
    xact(0, 32'd39, '0, -1, 1, 32'd5, 0, 0, 1, 32'd5);

    // Reset while a read miss is outstanding
    cpu_addr = 32'd200; cpu_read = 1; ram_wait = 1;
    set_exp(1, 0, 0, 0, 0, '0, 0, '0, 0, '0);
    step();
    set_exp(1, 1, 0, 0, 1, 32'd200, 0, '0, 0, '0);
    step();
    rst_n = 0;
    set_exp(0, 0, 0, 0, 1, '0, 1, '0, 1, '0);
    step();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    rst_n = 1; cpu_read = 0;
    set_exp(0, 0, 0, 0, 0, '0, 0, '0, 0, '0);
    step();
    xact(0, 32'd40, '0, -1, 0, '0, 0, 0, 0, '0);
    xact(0, 32'd39, '0, -1, 0, '0, 0, 0, 0, '0);

    for (int i = 0; i < 4; i++) xact(1, i, $urandom, -1, 0, '0, 0, -1, 0, '0);
    for (int t = 0; t < 300; t++) begin
      int          r, k;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      k = (r < 4) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
      a = (32'($urandom_range(0, 2)) << 4) | 32'($urandom_range(0, 3));
      xact(k, a, $urandom, -1, 0, '0, $urandom_range(0, 1), -1, 0, '0);
    end

    exp_en = 0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
